// File: rtl/fifo_ptr_pkg.sv
// Shared pointer helpers for both sides of the dual-clock FIFO (binary/Gray conversion, defaults).
// Latency: none; pure functions and constants.
// Backpressure: not applicable.
// Contents: DEFAULT_PTR_WIDTH, PTR_MAX_WIDTH, ptr_max_t, wflags_t, bin2gray(), gray2bin().
package fifo_ptr_pkg;

  localparam int DEFAULT_PTR_WIDTH = 3;

  // Conversion helpers work at a fixed maximum width; callers zero-extend
  // their pointer into it and truncate the result back down. Leading zeros
  // convert to leading zeros in both directions, so the low bits stay exact.
  localparam int PTR_MAX_WIDTH = 16;

  typedef logic [PTR_MAX_WIDTH-1:0] ptr_max_t;

  // Registered status flags presented to the upstream writer.
  typedef struct packed {
    logic full;
    logic almost_full;
    logic overflow;
  } wflags_t;

  function automatic ptr_max_t bin2gray(input ptr_max_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it.
  function automatic ptr_max_t gray2bin(input ptr_max_t gray);
    ptr_max_t bin;
    bin = gray;
    for (int i = PTR_MAX_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/wptr_handler_if.sv
// Write-side bundle between the upstream writer / FIFO memory and the write pointer handler.
// Latency: wires only.
// Backpressure: w_accept is the writer's acceptance indication; full/almost_full are advisory.
// Ports: w_en, g_rptr (into the handler); w_accept, b_wptr, g_wptr, full, almost_full, wlevel, overflow (out of it).
interface wptr_handler_if
  import fifo_ptr_pkg::*;
#(
  parameter int PTR_WIDTH = DEFAULT_PTR_WIDTH
);

  logic                 w_en;
  logic [PTR_WIDTH:0]   g_rptr;
  logic                 w_accept;
  logic [PTR_WIDTH:0]   b_wptr;
  logic [PTR_WIDTH:0]   g_wptr;
  logic                 full;
  logic                 almost_full;
  logic [PTR_WIDTH:0]   wlevel;
  logic                 overflow;

  // Writer side: issues write requests and forwards the read-domain Gray pointer.
  modport master (
    output w_en,
    output g_rptr,
    input  w_accept,
    input  b_wptr,
    input  g_wptr,
    input  full,
    input  almost_full,
    input  wlevel,
    input  overflow
  );

  // Pointer handler side.
  modport slave (
    input  w_en,
    input  g_rptr,
    output w_accept,
    output b_wptr,
    output g_wptr,
    output full,
    output almost_full,
    output wlevel,
    output overflow
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing a Gray-coded pointer into the local clock domain.
// Latency: 2 clk edges from d to q.
// Backpressure: none; samples every edge.
// Ports: clk, rst (sync, active-high, clears both stages), d (async input), q (stage-2 output).
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage1;
  logic [W-1:0] stage2;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage1 <= '0;
      stage2 <= '0;
    end else begin
      stage1 <= d;
      stage2 <= stage1;
    end
  end

  assign q = stage2;

endmodule

// File: rtl/wptr_handler.sv
// Write pointer and flag controller for the dual-clock FIFO feeding the AXI/DDR write path.
// Latency: accepted write updates pointers and flags at the same edge; read pointer reaches flags after 3 edges.
// Backpressure: w_accept = w_en & !full (registered full); writes while full are dropped and set sticky overflow.
// Ports: wclk, wrst (sync, active-high); bus (slave): w_en, g_rptr in; w_accept, b_wptr, g_wptr, full,
//        almost_full, wlevel, overflow out.
module wptr_handler
  import fifo_ptr_pkg::*;
#(
  parameter int PTR_WIDTH = DEFAULT_PTR_WIDTH,
  parameter int AF_THRESH = 6
) (
  input  logic           wclk,
  input  logic           wrst,
  wptr_handler_if.slave  bus
);

  localparam int PW1   = PTR_WIDTH + 1;
  localparam int DEPTH = 1 << PTR_WIDTH;

  // Threshold at pointer width; AF_THRESH <= DEPTH always fits in PW1 bits.
  localparam logic [PTR_WIDTH:0] AF_LIMIT = PW1'(AF_THRESH);

  if (PTR_WIDTH < 2 || PW1 > PTR_MAX_WIDTH) begin : g_bad_ptr_width
    $error("wptr_handler: PTR_WIDTH out of range");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af_thresh
    $error("wptr_handler: AF_THRESH out of range");
  end

  // Registered state
  logic [PTR_WIDTH:0] b_wptr_q;
  logic [PTR_WIDTH:0] g_wptr_q;
  logic [PTR_WIDTH:0] wlevel_q;
  wflags_t            flags_q;

  // Synchronized read pointer
  logic [PTR_WIDTH:0] g_rptr_sync;
  logic [PTR_WIDTH:0] b_rptr_sync;

  // Next-state values
  logic               w_accept;
  logic [PTR_WIDTH:0] b_wptr_next;
  logic [PTR_WIDTH:0] g_wptr_next;
  logic [PTR_WIDTH:0] g_rptr_full_pat;
  logic [PTR_WIDTH:0] level_next;
  logic               full_next;
  logic               af_next;

  sync_2ff #(
    .W (PW1)
  ) u_rptr_sync (
    .clk (wclk),
    .rst (wrst),
    .d   (bus.g_rptr),
    .q   (g_rptr_sync)
  );

  // Only the registered full gates acceptance, so the memory write strobe
  // never sits behind the pointer comparison logic.
  assign w_accept = bus.w_en & ~flags_q.full;

  always_comb begin
    b_wptr_next = b_wptr_q + {{PTR_WIDTH{1'b0}}, w_accept};
    g_wptr_next = PW1'(bin2gray(PTR_MAX_WIDTH'(b_wptr_next)));
    b_rptr_sync = PW1'(gray2bin(PTR_MAX_WIDTH'(g_rptr_sync)));

    // Full when the write pointer is exactly one lap ahead of the read
    // pointer: in Gray code that is the top two bits inverted, rest equal.
    g_rptr_full_pat = {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync[PTR_WIDTH-2:0]};
    full_next       = (g_wptr_next == g_rptr_full_pat);

    // Modular difference of extended pointers gives 0..DEPTH directly.
    level_next = b_wptr_next - b_rptr_sync;
    af_next    = (level_next >= AF_LIMIT);
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      b_wptr_q <= '0;
      g_wptr_q <= '0;
      wlevel_q <= '0;
      flags_q  <= '0;
    end else begin
      b_wptr_q            <= b_wptr_next;
      g_wptr_q            <= g_wptr_next;
      wlevel_q            <= level_next;
      flags_q.full        <= full_next;
      flags_q.almost_full <= af_next;
      // Sticky: a dropped write must stay visible until the writer resets us.
      if (bus.w_en & flags_q.full) begin
        flags_q.overflow <= 1'b1;
      end
    end
  end

  assign bus.w_accept    = w_accept;
  assign bus.b_wptr      = b_wptr_q;
  assign bus.g_wptr      = g_wptr_q;
  assign bus.wlevel      = wlevel_q;
  assign bus.full        = flags_q.full;
  assign bus.almost_full = flags_q.almost_full;
  assign bus.overflow    = flags_q.overflow;

  // A write attempted while full must leave the pointer untouched.
  a_hold_when_full : assert property (
    @(posedge wclk) disable iff (wrst)
    (bus.w_en & flags_q.full) |=> $stable(b_wptr_q)
  );

  // Overflow only clears through reset.
  a_overflow_sticky : assert property (
    @(posedge wclk) disable iff (wrst)
    flags_q.overflow |=> flags_q.overflow
  );

endmodule

// File: doc/wptr_handler.md
# wptr_handler

Write-side pointer and flag controller for the dual-clock FIFO between the packer and the AXI/DDR write path. It owns the binary and Gray write pointers and brings the read-domain Gray pointer into `wclk` through an internal 2-flop synchronizer. From these it produces registered `full`, `almost_full`, fill-level and sticky-overflow indications for the upstream writer. Its Gray write pointer is the value the read-side pointer handler synchronizes for its empty flag.

## Interface
- `PTR_WIDTH`, 3: address width. FIFO depth DEPTH = 2^PTR_WIDTH. Pointers are PTR_WIDTH+1 bits. Legal range is PTR_WIDTH ≥ 2.
- `AF_THRESH`, 6: `almost_full` asserts when the fill level is ≥ AF_THRESH. Legal range is 1..DEPTH.
- `wclk`  in  1  write-domain clock; the only clock.
- `wrst`  in  1  synchronous, active-high reset.
- `w_en`  in  1  write request from the upstream writer.
- `g_rptr`  in  PTR_WIDTH+1  Gray read pointer, asynchronous to `wclk`.
- `w_accept`  out  1  combinational `w_en & !full`; write strobe for the FIFO memory.
- `b_wptr`  out  PTR_WIDTH+1  binary write pointer. Memory address is `b_wptr[PTR_WIDTH-1:0]`.
- `g_wptr`  out  PTR_WIDTH+1  registered Gray write pointer, sent to the read domain.
- `full`  out  1  registered full flag.
- `almost_full`  out  1  registered threshold flag.
- `wlevel`  out  PTR_WIDTH+1  registered fill level, range 0..DEPTH.
- `overflow`  out  1  sticky; set by a write attempted while `full`.

## Operation
- **Reset.** While `wrst` is high at a `wclk` edge, the following all load 0, regardless of `w_en`:
  - `b_wptr`, `g_wptr`
  - both synchronizer stages
  - `full`, `almost_full`, `wlevel`, `overflow`
- **Synchronizer.** `g_rptr` passes through two flops, stage1 then stage2. `g_rptr_sync` is the stage2 output.
- **Next-state values.**
  - `b_wptr_next = b_wptr + w_accept`, wrapping modulo 2^(PTR_WIDTH+1).
  - `g_wptr_next = (b_wptr_next >> 1) ^ b_wptr_next`.
- **Full.** `full_next = (g_wptr_next == {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync[PTR_WIDTH-2:0]})`.
- **Level.** `level_next = b_wptr_next - gray2bin(g_rptr_sync)`, modulo 2^(PTR_WIDTH+1).
- **Almost full.** `af_next = (level_next >= AF_THRESH)`.
- **Register updates.** Every non-reset edge: `b_wptr`, `g_wptr`, `full`, `wlevel` and `almost_full` load their `_next` values.
- **Overflow.** Set at the edge where `w_en & full` is true; cleared only by `wrst`.
- **Write while full.** Ignored: the pointers hold and no memory write occurs (`w_accept` = 0).
- **Wrap-around.** The MSB toggles each time the pointer passes DEPTH. For PTR_WIDTH=3, `g_wptr` goes 4'b1000 → 4'b0000 when `b_wptr` wraps 15 → 0.
- **Simultaneous events.**
  - A write accepted in the same cycle as a read-pointer change is counted.
  - The flags reflect the synchronized read pointer, so they are pessimistic: `full` and `wlevel` may over-report but never under-report.

## Timing
- **Write acceptance.** An accepted write in cycle N updates `b_wptr` and `g_wptr` at the end of N. `full`, `almost_full` and `wlevel` reflect that write at the same edge (zero added latency).
- **Back-to-back writes.** Sustained at 1 per cycle until full.
- **Full assertion.** The write that makes the FIFO full also asserts `full` at that edge. A `w_en` in the next cycle is rejected.
- **Read-pointer latency.** A change on `g_rptr` is first reflected in `full`, `almost_full` and `wlevel` after the 3rd `wclk` edge: stage1, stage2, flag register.
- **`w_accept`.** Same-cycle combinational output. It depends only on `w_en` and the registered `full`, never on a `_next` value.
- **Reset exit.** The first cycle after `wrst` deasserts accepts writes.

## Structure
- **Package `fifo_ptr_pkg`.**
  - `bin2gray` and `gray2bin` functions, written at a max width of 16 and sliced by the caller.
  - `DEFAULT_PTR_WIDTH` = 3.
  - Shared with the read-side pointer handler.
- **Sub-module `sync_2ff #(W)`.** Two-stage, reset-to-0 synchronizer, instantiated once for `g_rptr`. The read side reuses it for `g_wptr`.
- Everything else stays flat in `wptr_handler`.

## Test plan
Bench settings: PTR_WIDTH=3, AF_THRESH=6, `g_rptr`=0 unless stated.
- **Reset with write pending.** `wrst`=1 for 2 edges with `w_en`=1 → all outputs 0 and `overflow`=0. The first post-reset `w_en` is accepted, giving `b_wptr`=1.
- **Fill.** 8 cycles of `w_en`=1:
  - after the 6th edge: `almost_full`=1, `wlevel`=6;
  - after the 8th edge: `b_wptr`=8, `g_wptr`=4'b1100, `full`=1, `wlevel`=8.
- **Overflow.** One further `w_en`=1 cycle → `w_accept`=0 and `b_wptr` holds at 8. `overflow`=1 and stays 1 after `w_en` drops.
- **Release from full.** Drive `g_rptr`=4'b0001 (read ptr 1) → 3 edges later `full`=0, `wlevel`=7, `almost_full`=1. Then drive `g_rptr`=4'b0010 (read ptr 3) → 3 edges later `wlevel`=5, `almost_full`=0.
- **Wrap-around.** Write 20 words while `g_rptr` follows the write pointer with a 4-write lag:
  - `b_wptr` wraps 15 → 0 with `g_wptr` going 4'b1000 → 4'b0000;
  - `full` never asserts;
  - `wlevel` never exceeds 7.
- **Reset mid-fill.** After 5 writes, assert `wrst` for 1 edge with `w_en`=1 → the next cycle shows all outputs 0 and `overflow`=0.
